// File: rtl/ac97_rx_deframer.sv
// AC97 receive deframer: locks to the controller's sync edges and decodes tag, status and PCM capture slots.
// Optional frame/error statistics outputs are built when AC97_RX_STATS_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_HUNT  | not locked; data ignored until a sync rising edge
// ST_FRAME | locked; bitcnt holds the index of the last sampled frame bit
module ac97_rx_deframer #(
   parameter int PCM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_b,
   input  logic                 ac97_sync,
   input  logic                 ac97_sdata_in,
   output logic                 codec_ready,
   output logic [4:0]           slot_valid,
   output logic [6:0]           status_addr,
   output logic [9:0]           status_slotreq,
   output logic [15:0]          status_data,
   output logic                 status_valid,
   output logic [PCM_WIDTH-1:0] pcm_left,
   output logic [PCM_WIDTH-1:0] pcm_right,
   output logic [1:0]           pcm_valid,
   output logic                 locked,
   output logic                 frame_error
`ifdef AC97_RX_STATS_EN
   ,
   output logic [15:0]          frame_count,
   output logic [7:0]           error_count
`endif
);

   typedef enum logic {ST_HUNT, ST_FRAME} state_t;

   state_t      state;
   logic        sync_prev;
   logic [7:0]  bitcnt;
   logic [18:0] shift_reg;
   logic [16:0] slot1_hold;

   logic        sync_edge;
   logic [7:0]  next_cnt;
   logic [19:0] word;
   logic        err_now;
   logic        frame_done;

   // word is the 20-bit slot view including the bit sampled this cycle
   always_comb begin
      sync_edge  = ac97_sync & ~sync_prev;
      next_cnt   = bitcnt + 8'd1;
      word       = {shift_reg, ac97_sdata_in};
      err_now    = 1'b0;
      frame_done = 1'b0;
      if (state == ST_FRAME) begin
         if (sync_edge) begin
            err_now = (bitcnt != 8'hFF);
         end else begin
            err_now    = (bitcnt == 8'hFF);
            frame_done = (next_cnt == 8'hFF);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state          <= ST_HUNT;
         sync_prev      <= 1'b0;
         bitcnt         <= 8'd0;
         shift_reg      <= '0;
         slot1_hold     <= '0;
         codec_ready    <= 1'b0;
         slot_valid     <= '0;
         status_addr    <= '0;
         status_slotreq <= '0;
         status_data    <= '0;
         status_valid   <= 1'b0;
         pcm_left       <= '0;
         pcm_right      <= '0;
         pcm_valid      <= '0;
         locked         <= 1'b0;
         frame_error    <= 1'b0;
      end else begin
         sync_prev    <= ac97_sync;
         status_valid <= 1'b0;
         pcm_valid    <= 2'b00;
         frame_error  <= err_now;
         case (state)
            ST_HUNT: begin
               if (sync_edge) begin
                  state     <= ST_FRAME;
                  locked    <= 1'b1;
                  bitcnt    <= 8'd0;
                  shift_reg <= word[18:0];
               end
            end
            ST_FRAME: begin
               if (sync_edge) begin
                  // expected or early edge: either way this bit is frame bit 0
                  bitcnt    <= 8'd0;
                  shift_reg <= word[18:0];
               end else if (bitcnt == 8'hFF) begin
                  state  <= ST_HUNT;
                  locked <= 1'b0;
               end else begin
                  bitcnt    <= next_cnt;
                  shift_reg <= word[18:0];
                  case (next_cnt)
                     8'd15: begin
                        codec_ready <= word[15];
                        slot_valid  <= word[15:11];
                     end
                     8'd35: slot1_hold <= word[18:2];
                     8'd55: begin
                        if (slot_valid[4] && slot_valid[3] && slot_valid[2]) begin
                           status_addr    <= slot1_hold[16:10];
                           status_slotreq <= slot1_hold[9:0];
                           status_data    <= word[19:4];
                           status_valid   <= 1'b1;
                        end
                     end
                     8'd75: begin
                        if (slot_valid[4] && slot_valid[1]) begin
                           pcm_left     <= word[19 -: PCM_WIDTH];
                           pcm_valid[1] <= 1'b1;
                        end
                     end
                     8'd95: begin
                        if (slot_valid[4] && slot_valid[0]) begin
                           pcm_right    <= word[19 -: PCM_WIDTH];
                           pcm_valid[0] <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: state <= ST_HUNT;
         endcase
      end
   end

`ifdef AC97_RX_STATS_EN
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         frame_count <= '0;
         error_count <= '0;
      end else begin
         if (frame_done)
            frame_count <= frame_count + 16'd1;
         if (err_now && error_count != 8'hFF)
            error_count <= error_count + 8'd1;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = frame_done;
`endif

endmodule

// File: tb/tb_ac97_rx_deframer.sv
// Bench for ac97_rx_deframer: frame-level expectation model plus literal pins on the directed frames.
module tb_ac97_rx_deframer;

   localparam int PW   = 16;
   localparam int MAXN = 2048;
   localparam int H_CR = 0, H_SV = 1, H_SA = 2, H_SR = 3, H_SD = 4;
   localparam int H_PL = 5, H_PR = 6, H_LK = 7, H_FC = 8, H_EC = 9;
   localparam int P_STV = 0, P_PV = 1, P_FE = 2;

   logic          clk = 1'b0;
   logic          reset_b;
   logic          ac97_sync;
   logic          ac97_sdata_in;
   logic          codec_ready;
   logic [4:0]    slot_valid;
   logic [6:0]    status_addr;
   logic [9:0]    status_slotreq;
   logic [15:0]   status_data;
   logic          status_valid;
   logic [PW-1:0] pcm_left;
   logic [PW-1:0] pcm_right;
   logic [1:0]    pcm_valid;
   logic          locked;
   logic          frame_error;
`ifdef AC97_RX_STATS_EN
   logic [15:0]   frame_count;
   logic [7:0]    error_count;
`endif

   always #5 clk = ~clk;

   ac97_rx_deframer #(.PCM_WIDTH(PW)) dut (
      .clk            (clk),
      .reset_b        (reset_b),
      .ac97_sync      (ac97_sync),
      .ac97_sdata_in  (ac97_sdata_in),
      .codec_ready    (codec_ready),
      .slot_valid     (slot_valid),
      .status_addr    (status_addr),
      .status_slotreq (status_slotreq),
      .status_data    (status_data),
      .status_valid   (status_valid),
      .pcm_left       (pcm_left),
      .pcm_right      (pcm_right),
      .pcm_valid      (pcm_valid),
      .locked         (locked),
      .frame_error    (frame_error)
`ifdef AC97_RX_STATS_EN
      ,
      .frame_count    (frame_count),
      .error_count    (error_count)
`endif
   );

   // expected held outputs and pulses, indexed by the clock edge that sampled the input bit
   logic [31:0] hold_m  [10][MAXN];
   logic [31:0] pulse_m [3][MAXN];
   logic        s_sync  [MAXN];
   logic        s_data  [MAXN];
   int n_stim   = 0;
   int n_checks = 0;
   int n_fail   = 0;
   int model_fc = 0;
   int model_ec = 0;
   int c_a, c_b, c_c, c_d, c_e, c_f;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int at);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", nm, at, act, exp);
      end
   endtask

   task automatic fill(input int id, input int from, input logic [31:0] v);
      for (int k = from; k < MAXN; k++) hold_m[id][k] = v;
   endtask

   task automatic pulse(input int id, input int at, input logic [31:0] v);
      pulse_m[id][at] = pulse_m[id][at] | v;
   endtask

   task automatic err_inc(input int at);
      if (model_ec < 255) model_ec++;
      fill(H_EC, at, 32'(model_ec));
   endtask

   task automatic put(input logic s, input logic d);
      s_sync[n_stim] = s;
      s_data[n_stim] = d;
      n_stim++;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) put(1'b0, 1'($urandom_range(1, 0)));
   endtask

   // one frame of len bits (len < 256 means the next frame's sync arrives early)
   task automatic add_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int len,
                            input int slen, input bit ends_missing, output int c);
      logic [95:0] payload;
      payload = {tag, s1, s2, s3, s4};
      c = n_stim;
      for (int i = 0; i < len; i++)
         put(i < slen, (i < 96) ? payload[95-i] : 1'($urandom_range(1, 0)));
      fill(H_LK, c, 32'd1);
      if (len > 15) begin
         fill(H_CR, c + 15, 32'(tag[15]));
         fill(H_SV, c + 15, 32'(tag[15:11]));
      end
      if (len > 55 && tag[15] && tag[14] && tag[13]) begin
         fill(H_SA, c + 55, 32'(s1[18:12]));
         fill(H_SR, c + 55, 32'(s1[11:2]));
         fill(H_SD, c + 55, 32'(s2[19:4]));
         pulse(P_STV, c + 55, 32'd1);
      end
      if (len > 75 && tag[15] && tag[12]) begin
         fill(H_PL, c + 75, 32'(s3 >> (20 - PW)));
         pulse(P_PV, c + 75, 32'd2);
      end
      if (len > 95 && tag[15] && tag[11]) begin
         fill(H_PR, c + 95, 32'(s4 >> (20 - PW)));
         pulse(P_PV, c + 95, 32'd1);
      end
      if (len == 256) begin
         model_fc++;
         fill(H_FC, c + 255, 32'(model_fc & 16'hFFFF));
      end else begin
         pulse(P_FE, c + len, 32'd1);
         err_inc(c + len);
      end
      if (ends_missing) begin
         pulse(P_FE, c + 256, 32'd1);
         fill(H_LK, c + 256, 32'd0);
         err_inc(c + 256);
      end
   endtask

   task automatic check_all_zero(input string tag_nm);
      chk({tag_nm, " codec_ready"}, 32'(codec_ready), 32'd0, -1);
      chk({tag_nm, " slot_valid"}, 32'(slot_valid), 32'd0, -1);
      chk({tag_nm, " status_addr"}, 32'(status_addr), 32'd0, -1);
      chk({tag_nm, " status_data"}, 32'(status_data), 32'd0, -1);
      chk({tag_nm, " pcm_left"}, 32'(pcm_left), 32'd0, -1);
      chk({tag_nm, " pulses"}, 32'({status_valid, pcm_valid, frame_error}), 32'd0, -1);
      chk({tag_nm, " locked"}, 32'(locked), 32'd0, -1);
   endtask

   initial begin
      for (int id = 0; id < 10; id++) for (int k = 0; k < MAXN; k++) hold_m[id][k] = '0;
      for (int id = 0; id < 3; id++) for (int k = 0; k < MAXN; k++) pulse_m[id][k] = '0;

      idle(300);
      add_frame(16'hE000, 20'h26000, 20'h800F0, 20'h11111, 20'h22222, 256, 16, 1'b0, c_a);
      add_frame(16'h9800, 20'h3C3C3, 20'h0F0F0, 20'hABCDE, 20'h12345, 256, 40, 1'b0, c_b);
      add_frame(16'h7800, 20'hFFFFF, 20'hAAAAA, 20'h55555, 20'h77777, 256, 16, 1'b0, c_c);
      add_frame(16'hF800, 20'h0ABC4, 20'h55AA0, 20'hFEDCB, 20'h0F0F0, 100, 16, 1'b0, c_d);
      add_frame(16'hF800, 20'h7F004, 20'hC3A50, 20'h13579, 20'h2468A, 256, 16, 1'b1, c_e);
      idle(20);
      add_frame(16'hE000, 20'hF3FFC, 20'h1234A, 20'h00000, 20'h00000, 256, 16, 1'b1, c_f);
      idle(20);

      reset_b = 1'b0;
      ac97_sync = 1'b0;
      ac97_sdata_in = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_b = 1'b1;
      ac97_sync = s_sync[0];
      ac97_sdata_in = s_data[0];

      for (int k = 0; k < n_stim; k++) begin
         @(negedge clk);
         chk("codec_ready", 32'(codec_ready), hold_m[H_CR][k], k);
         chk("slot_valid", 32'(slot_valid), hold_m[H_SV][k], k);
         chk("status_addr", 32'(status_addr), hold_m[H_SA][k], k);
         chk("status_slotreq", 32'(status_slotreq), hold_m[H_SR][k], k);
         chk("status_data", 32'(status_data), hold_m[H_SD][k], k);
         chk("status_valid", 32'(status_valid), pulse_m[P_STV][k], k);
         chk("pcm_left", 32'(pcm_left), hold_m[H_PL][k], k);
         chk("pcm_right", 32'(pcm_right), hold_m[H_PR][k], k);
         chk("pcm_valid", 32'(pcm_valid), pulse_m[P_PV][k], k);
         chk("locked", 32'(locked), hold_m[H_LK][k], k);
         chk("frame_error", 32'(frame_error), pulse_m[P_FE][k], k);
`ifdef AC97_RX_STATS_EN
         chk("frame_count", 32'(frame_count), hold_m[H_FC][k], k);
         chk("error_count", 32'(error_count), hold_m[H_EC][k], k);
`endif
         if (k == c_a + 55) begin
            chk("pin status_valid", 32'(status_valid), 32'd1, k);
            chk("pin status_addr", 32'(status_addr), 32'h26, k);
            chk("pin status_data", 32'(status_data), 32'h800F, k);
            chk("pin codec_ready", 32'(codec_ready), 32'd1, k);
            chk("pin slot_valid", 32'(slot_valid), 32'b11100, k);
         end
         if (k == c_b + 75) begin
            chk("pin pcm_left", 32'(pcm_left), 32'hABCD, k);
            chk("pin pcm_valid left", 32'(pcm_valid), 32'b10, k);
         end
         if (k == c_b + 95) begin
            chk("pin pcm_right", 32'(pcm_right), 32'h1234, k);
            chk("pin pcm_valid right", 32'(pcm_valid), 32'b01, k);
         end
         if (k == c_c + 20) begin
            chk("pin not ready codec_ready", 32'(codec_ready), 32'd0, k);
            chk("pin not ready locked", 32'(locked), 32'd1, k);
         end
         if (k == c_d + 100)
            chk("pin early sync frame_error", 32'(frame_error), 32'd1, k);
         if (k == c_e + 256) begin
            chk("pin missing sync frame_error", 32'(frame_error), 32'd1, k);
            chk("pin missing sync locked", 32'(locked), 32'd0, k);
         end
         if (k == c_f + 55)
            chk("pin relock status_data", 32'(status_data), 32'h1234, k);
         ac97_sync     = (k + 1 < n_stim) ? s_sync[k+1] : 1'b0;
         ac97_sdata_in = (k + 1 < n_stim) ? s_data[k+1] : 1'b0;
      end

      // asynchronous reset in the middle of a locked frame
      for (int i = 0; i < 60; i++) begin
         ac97_sync     = (i < 16);
         ac97_sdata_in = (i < 5) ? 1'b1 : 1'($urandom_range(1, 0));
         @(negedge clk);
      end
      chk("midframe codec_ready", 32'(codec_ready), 32'd1, -1);
      chk("midframe locked", 32'(locked), 32'd1, -1);
      #2 reset_b = 1'b0;
      #1 check_all_zero("async reset");
      ac97_sync = 1'b0;
      @(negedge clk);
      reset_b = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post reset pulses", 32'({status_valid, pcm_valid, frame_error}), 32'd0, -1);
         chk("post reset locked", 32'(locked), 32'd0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ac97_rx_deframer.md
Name: ac97_rx_deframer

Overview:
- Receive-side counterpart to the AC97 serial output path. It deserialises the codec's ac97_sdata_in stream, which is framed by the controller's own ac97_sync.
- Decodes the tag slot, the register status (slots 1/2) and the PCM capture data (slots 3/4).
- Sits beside the AC97 transmitter in the audio top and is clocked by ac97_bitclk. Its outputs feed codec-ready gating, codec register read-back and record/loopback logic.

Parameters:
- PCM_WIDTH, 16, number of MSBs of each 20-bit PCM slot presented on pcm_left/pcm_right; legal range 1..20.

Ports:
- clk  input  1  ac97_bitclk; all logic on rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- ac97_sync  input  1  frame sync driven by the controller; sampled on clk.
- ac97_sdata_in  input  1  serial data from the codec, MSB first; sampled on clk.
- codec_ready  output  1  tag bit 15 of the last completed tag slot.
- slot_valid  output  5  tag bits 15:11 of the last tag slot {ready, s1, s2, s3, s4}.
- status_addr  output  7  slot1 bits 18:12, the register index.
- status_slotreq  output  10  slot1 bits 11:2, the slot request bits.
- status_data  output  16  slot2 bits 19:4.
- status_valid  output  1  one-cycle pulse when new status is available.
- pcm_left  output  PCM_WIDTH  slot3 bits 19:(20-PCM_WIDTH).
- pcm_right  output  PCM_WIDTH  slot4 bits 19:(20-PCM_WIDTH).
- pcm_valid  output  2  one-cycle pulse per channel {left, right}.
- locked  output  1  high while in FRAME state.
- frame_error  output  1  one-cycle pulse on a sync error.

Behaviour:
- Reset: every output is 0. State is HUNT, bit counter is 0, shift register is 0, sync history is 0.
- Sync edge: a sync edge is a cycle where ac97_sync is sampled 1 and the previous sample was 0. The data bit sampled in that same cycle is frame bit 0 (tag bit 15).
- States:
  - HUNT: ignore data. On a sync edge, go to FRAME with bitcnt=0.
  - FRAME: bitcnt (8 bits) increments every cycle and wraps 255 to 0.
- Frame bit mapping:
  - Bits 0..15: tag slot.
  - Bits 16..35: slot1.
  - Bits 36..55: slot2.
  - Bits 56..75: slot3.
  - Bits 76..95: slot4.
  - Bits 96..255: sampled but discarded.
- Shift register: a 20-bit register shifts left with the new bit in bit 0. Field capture uses the register value including the current bit, at the slot's last bit.
- Tag capture: at bitcnt=15, codec_ready and slot_valid are loaded from the tag word and held until the next tag.
- Status capture:
  - At bitcnt=35, a slot1 capture is held internally.
  - At bitcnt=55, if the current tag has ready=1, s1=1 and s2=1, then status_addr, status_slotreq and status_data update in that cycle. status_valid pulses in the following cycle, aligned with the updated outputs.
  - Otherwise the status outputs hold and there is no pulse.
- PCM capture:
  - At bitcnt=75, if ready=1 and s3=1, pcm_left updates and pcm_valid[1] pulses on the next cycle.
  - At bitcnt=95, if ready=1 and s4=1, pcm_right updates and pcm_valid[0] pulses on the next cycle.
- Sync checks while in FRAME:
  - Expected: a sync edge occurs exactly when bitcnt would wrap to 0.
  - Sync edge at any other bitcnt: frame_error pulses next cycle, bitcnt forces to 0 and a new frame starts at that bit. Partial-slot captures from the aborted frame are discarded.
  - No sync edge at the wrap point: frame_error pulses and the block goes to HUNT with locked=0.
- Sync held high beyond 16 bits: not an error; only edges matter.
- Asynchronous reset mid-frame: immediately returns to the reset state. No pulse is emitted on release.
- Pulses are never longer than one cycle. pcm_valid bits may pulse in different cycles within one frame.

Optional Feature:
- Macro: AC97_RX_STATS_EN.
- When defined, adds these outputs:
  - frame_count[15:0]: counts frames completed while locked; wraps.
  - error_count[7:0]: counts frame_error pulses; saturates at 255.
  - Both reset to 0.
- When undefined, these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle (sync=0) for 300 cycles -> all outputs 0, locked=0, no pulses.
- Sync edge, then tag 0xE000, slot1 index 7'h26 with slotreq 10'h000, slot2 data 16'h800F -> status_valid pulses once at frame bit 56; status_addr=7'h26, status_data=16'h800F; codec_ready=1; slot_valid=5'b11100.
- Tag 0x9800, slot3 20'hABCDE, slot4 20'h12345, PCM_WIDTH=16 -> pcm_left=16'hABCD with pcm_valid=2'b10 at frame bit 76; pcm_right=16'h1234 with pcm_valid=2'b01 at frame bit 96; no status_valid.
- Tag 0x7800, bit 15 clear -> no status or PCM updates and codec_ready=0, while locked stays 1.
- Early sync edge at bitcnt=100 -> frame_error pulses; a new frame decodes correctly from that edge.
- Missing sync at the wrap point -> frame_error pulses, locked=0, and relock on the next edge.
- With AC97_RX_STATS_EN: 3 good frames then 1 missing sync -> frame_count=3, error_count=1.
